// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles every request, response and RAM-side signal of the RAM arbiter
// into one interface so the arbiter and its users connect through one port.
//
// Signals:
//   reqValid/reqReady    request handshake, bit0 = LSU port, bit1 = fetch port
//   reqAddr0/1           byte address per port
//   reqWrite0/1          1 = store
//   reqSize0/1           funct3 size code ([1:0] size, [2] unsigned load)
//   reqWdata0/1          right-aligned store data
//   rspValid/rspReady    response handshake per port
//   rspRdata/rspErr      shared response payload
//   memAddress           RAM word address
//   memWriteData         lane-replicated write word
//   memWrite/byteMask    RAM write enable and byte-lane enables
//   memReadData          RAM read data, one cycle after the read is issued
//
// Modports:
//   slave   the arbiter side
//   master  the requester / RAM side (used by the testbench)
interface ram_arbiter_if;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [31:0] reqAddr0;
    logic [31:0] reqAddr1;
    logic        reqWrite0;
    logic        reqWrite1;
    logic [2:0]  reqSize0;
    logic [2:0]  reqSize1;
    logic [31:0] reqWdata0;
    logic [31:0] reqWdata1;
    logic [1:0]  rspValid;
    logic [1:0]  rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic [3:0]  byteMask;
    logic [31:0] memReadData;

    modport slave (
        input  reqValid, reqAddr0, reqAddr1, reqWrite0, reqWrite1,
               reqSize0, reqSize1, reqWdata0, reqWdata1, rspReady, memReadData,
        output reqReady, rspValid, rspRdata, rspErr,
               memAddress, memWriteData, memWrite, byteMask
    );

    modport master (
        output reqValid, reqAddr0, reqAddr1, reqWrite0, reqWrite1,
               reqSize0, reqSize1, reqWdata0, reqWdata1, rspReady, memReadData,
        input  reqReady, rspValid, rspRdata, rspErr,
               memAddress, memWriteData, memWrite, byteMask
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one 32-bit single-port RAM between the load/store port (port 0)
// and the instruction-fetch port (port 1). Requests are granted round-robin
// with a single access outstanding. Byte/half/word accesses are turned into
// a word address, a lane-replicated write word and a byte mask; load data is
// lane-selected and sign/zero-extended. Misaligned or out-of-range accesses
// are answered with an error response without touching the RAM.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    ram_arbiter_if.slave (request/response channels and RAM side)
//
// Parameters:
//   ADDR_W  word-address width of the RAM; byte addresses use [ADDR_W+1:0]
module ram_arbiter #(
    parameter int ADDR_W = 14
) (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t      state;
    logic        lastGrant;
    logic        grantPort;
    logic [1:0]  latLane;
    logic        latWrite;
    logic [2:0]  latSize;

    logic [1:0]  rspValidQ;
    logic [31:0] rspRdataQ;
    logic        rspErrQ;
    logic [31:0] memAddressQ;
    logic [31:0] memWriteDataQ;
    logic [3:0]  byteMaskQ;

    logic [1:0]  grantVec;
    logic        selPort;
    logic [31:0] selAddr;
    logic [31:0] selWdata;
    logic        selWrite;
    logic [2:0]  selSize;
    logic        selErr;
    logic [3:0]  selMask;
    logic [31:0] selLaneData;

    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] loadData;

    // Round-robin grant. Only offered in IDLE; on a tie the port that did
    // not win last time gets the grant.
    always_comb begin
        grantVec = 2'b00;
        selPort  = 1'b0;
        if (state == IDLE && !reset) begin
            case (bus.reqValid)
                2'b01: begin
                    grantVec = 2'b01;
                    selPort  = 1'b0;
                end
                2'b10: begin
                    grantVec = 2'b10;
                    selPort  = 1'b1;
                end
                2'b11: begin
                    if (lastGrant) begin
                        grantVec = 2'b01;
                        selPort  = 1'b0;
                    end else begin
                        grantVec = 2'b10;
                        selPort  = 1'b1;
                    end
                end
                default: begin
                    grantVec = 2'b00;
                    selPort  = 1'b0;
                end
            endcase
        end
    end

    // Request fields of whichever port is being looked at this cycle.
    always_comb begin
        selAddr  = selPort ? bus.reqAddr1  : bus.reqAddr0;
        selWdata = selPort ? bus.reqWdata1 : bus.reqWdata0;
        selWrite = selPort ? bus.reqWrite1 : bus.reqWrite0;
        selSize  = selPort ? bus.reqSize1  : bus.reqSize0;
    end

    // Alignment, size-code and range checks on the request being accepted.
    always_comb begin
        selErr = 1'b0;
        if ((selAddr >> (ADDR_W + 2)) != 32'd0) begin
            selErr = 1'b1;
        end
        case (selSize[1:0])
            2'b01:   if (selAddr[0]) selErr = 1'b1;
            2'b10:   if (selAddr[1:0] != 2'b00) selErr = 1'b1;
            2'b11:   selErr = 1'b1;
            default: ;
        endcase
    end

    // Byte-lane mask and replicated write word. Reads always enable all
    // lanes so the RAM returns the whole word for lane selection later.
    always_comb begin
        case (selSize[1:0])
            2'b00: begin
                selMask     = 4'b0001 << selAddr[1:0];
                selLaneData = {4{selWdata[7:0]}};
            end
            2'b01: begin
                selMask     = 4'b0011 << {selAddr[1], 1'b0};
                selLaneData = {2{selWdata[15:0]}};
            end
            default: begin
                selMask     = 4'b1111;
                selLaneData = selWdata;
            end
        endcase
        if (!selWrite) begin
            selMask = 4'b1111;
        end
    end

    // Lane selection and extension of the word coming back from the RAM.
    always_comb begin
        case (latLane)
            2'b00:   byteVal = bus.memReadData[7:0];
            2'b01:   byteVal = bus.memReadData[15:8];
            2'b10:   byteVal = bus.memReadData[23:16];
            default: byteVal = bus.memReadData[31:24];
        endcase
        halfVal = latLane[1] ? bus.memReadData[31:16] : bus.memReadData[15:0];
        case (latSize[1:0])
            2'b00:   loadData = latSize[2] ? {24'h000000, byteVal}
                                           : {{24{byteVal[7]}}, byteVal};
            2'b01:   loadData = latSize[2] ? {16'h0000, halfVal}
                                           : {{16{halfVal[15]}}, halfVal};
            default: loadData = bus.memReadData;
        endcase
    end

    // Main controller. Requests are latched on the accept edge, so later
    // changes on the requester inputs cannot disturb the access. Good
    // requests go through ISSUE and CAPTURE; rejected ones jump straight
    // to RESP with the error flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lastGrant     <= 1'b1;
            grantPort     <= 1'b0;
            latLane       <= 2'b00;
            latWrite      <= 1'b0;
            latSize       <= 3'b000;
            rspValidQ     <= 2'b00;
            rspRdataQ     <= 32'd0;
            rspErrQ       <= 1'b0;
            memAddressQ   <= 32'd0;
            memWriteDataQ <= 32'd0;
            byteMaskQ     <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (grantVec != 2'b00) begin
                        lastGrant <= selPort;
                        grantPort <= selPort;
                        latLane   <= selAddr[1:0];
                        latWrite  <= selWrite;
                        latSize   <= selSize;
                        if (selErr) begin
                            rspErrQ   <= 1'b1;
                            rspRdataQ <= 32'd0;
                            rspValidQ <= selPort ? 2'b10 : 2'b01;
                            state     <= RESP;
                        end else begin
                            rspErrQ       <= 1'b0;
                            memAddressQ   <= 32'(selAddr[ADDR_W+1:2]);
                            memWriteDataQ <= selLaneData;
                            byteMaskQ     <= selMask;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    rspRdataQ <= latWrite ? 32'd0 : loadData;
                    rspErrQ   <= 1'b0;
                    rspValidQ <= grantPort ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rspReady[grantPort]) begin
                        rspValidQ <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The write strobe is gated by reset directly so a store whose ISSUE
    // cycle coincides with reset never reaches the RAM.
    assign bus.memWrite     = (state == ISSUE) && latWrite && !reset;
    assign bus.reqReady     = grantVec;
    assign bus.rspValid     = rspValidQ;
    assign bus.rspRdata     = rspRdataQ;
    assign bus.rspErr       = rspErrQ;
    assign bus.memAddress   = memAddressQ;
    assign bus.memWriteData = memWriteDataQ;
    assign bus.byteMask     = byteMaskQ;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed testbench for ram_arbiter: drives both requester ports through
// the interface, models a small registered-read RAM with byte-lane writes,
// and compares against hand-computed expected values.
module tb_ram_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] mem [0:63];

    ram_arbiter_if bus();

    ram_arbiter #(.ADDR_W(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM with per-lane write enables.
    always @(posedge clk) begin
        bus.memReadData <= mem[bus.memAddress[5:0]];
        if (bus.memWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteMask[b]) begin
                    mem[bus.memAddress[5:0]][8*b +: 8] <= bus.memWriteData[8*b +: 8];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete access on one port: request, accept, ISSUE/CAPTURE (or
    // error shortcut), optional response stall, handshake.
    task automatic applyStimulus(input string tag, input int port, input logic wr,
                                 input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic expErr,
                                 input logic [31:0] expRdata, input logic [3:0] expMask,
                                 input logic [31:0] expWd, input int stall);
        logic        granted;
        logic [31:0] expValid;
        logic [31:0] expAddr;
        expValid = (port == 1) ? 32'd2 : 32'd1;
        expAddr  = (addr >> 2) & 32'h0000_3FFF;
        @(negedge clk);
        if (port == 0) begin
            bus.reqAddr0  = addr;
            bus.reqWrite0 = wr;
            bus.reqSize0  = size;
            bus.reqWdata0 = wd;
            bus.reqValid  = 2'b01;
        end else begin
            bus.reqAddr1  = addr;
            bus.reqWrite1 = wr;
            bus.reqSize1  = size;
            bus.reqWdata1 = wd;
            bus.reqValid  = 2'b10;
        end
        granted = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.reqReady != 2'b00) begin
                granted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!granted) begin
            checkOutput({tag, " accept timeout"}, 32'd0, 32'd1);
            bus.reqValid = 2'b00;
            return;
        end
        checkOutput({tag, " reqReady"}, 32'(bus.reqReady), expValid);
        @(posedge clk);
        @(negedge clk);
        bus.reqValid  = 2'b00;
        bus.reqAddr0  = 32'hFFFF_FFFF;
        bus.reqAddr1  = 32'hFFFF_FFFF;
        bus.reqWdata0 = 32'h5A5A_5A5A;
        bus.reqWdata1 = 32'h5A5A_5A5A;
        bus.reqSize0  = 3'b011;
        bus.reqSize1  = 3'b011;
        if (expErr) begin
            checkOutput({tag, " err rspValid"}, 32'(bus.rspValid), expValid);
            checkOutput({tag, " err rspErr"}, 32'(bus.rspErr), 32'd1);
            checkOutput({tag, " err rspRdata"}, bus.rspRdata, 32'd0);
            checkOutput({tag, " err memWrite"}, 32'(bus.memWrite), 32'd0);
        end else begin
            checkOutput({tag, " issue memWrite"}, 32'(bus.memWrite), 32'(wr));
            checkOutput({tag, " issue memAddress"}, bus.memAddress, expAddr);
            checkOutput({tag, " issue byteMask"}, 32'(bus.byteMask), 32'(expMask));
            if (wr) begin
                checkOutput({tag, " issue memWriteData"}, bus.memWriteData, expWd);
            end
            checkOutput({tag, " issue rspValid"}, 32'(bus.rspValid), 32'd0);
            checkOutput({tag, " issue reqReady"}, 32'(bus.reqReady), 32'd0);
            @(negedge clk);
            checkOutput({tag, " capture memWrite"}, 32'(bus.memWrite), 32'd0);
            checkOutput({tag, " capture rspValid"}, 32'(bus.rspValid), 32'd0);
            @(negedge clk);
            checkOutput({tag, " rspValid"}, 32'(bus.rspValid), expValid);
            checkOutput({tag, " rspErr"}, 32'(bus.rspErr), 32'd0);
            checkOutput({tag, " rspRdata"}, bus.rspRdata, expRdata);
        end
        for (int s = 0; s < stall; s++) begin
            bus.rspReady = (port == 1) ? 2'b01 : 2'b10;
            @(negedge clk);
            checkOutput({tag, " stall rspValid"}, 32'(bus.rspValid), expValid);
            checkOutput({tag, " stall rspRdata"}, bus.rspRdata, expRdata);
        end
        bus.rspReady = (port == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        bus.rspReady = 2'b00;
        checkOutput({tag, " rspValid drop"}, 32'(bus.rspValid), 32'd0);
    endtask

    initial begin
        int grants;
        int cyc;
        int lastCyc;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        bus.reqValid    = 2'b00;
        bus.rspReady    = 2'b00;
        bus.reqAddr0    = 32'd0;
        bus.reqAddr1    = 32'd0;
        bus.reqWrite0   = 1'b0;
        bus.reqWrite1   = 1'b0;
        bus.reqSize0    = 3'b010;
        bus.reqSize1    = 3'b010;
        bus.reqWdata0   = 32'd0;
        bus.reqWdata1   = 32'd0;
        bus.memReadData = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values, with both ports requesting.
        bus.reqValid = 2'b11;
        #1;
        checkOutput("reset reqReady", 32'(bus.reqReady), 32'd0);
        checkOutput("reset rspValid", 32'(bus.rspValid), 32'd0);
        checkOutput("reset rspRdata", bus.rspRdata, 32'd0);
        checkOutput("reset rspErr", 32'(bus.rspErr), 32'd0);
        checkOutput("reset memWrite", 32'(bus.memWrite), 32'd0);
        checkOutput("reset byteMask", 32'(bus.byteMask), 32'd0);
        checkOutput("reset memAddress", bus.memAddress, 32'd0);
        checkOutput("reset memWriteData", bus.memWriteData, 32'd0);
        bus.reqValid = 2'b00;
        @(negedge clk);
        reset = 1'b0;

        // Word, byte and half stores and loads.
        applyStimulus("st word", 0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 4'b1111, 32'hDEADBEEF, 0);
        applyStimulus("ld word", 0, 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 4'b1111, 32'd0, 0);
        applyStimulus("st byte", 1, 1'b1, 3'b000, 32'h13, 32'h12345680, 1'b0, 32'd0, 4'b1000, 32'h80808080, 0);
        applyStimulus("ld byte s", 0, 1'b0, 3'b000, 32'h13, 32'd0, 1'b0, 32'hFFFFFF80, 4'b1111, 32'd0, 0);
        applyStimulus("ld byte u", 1, 1'b0, 3'b100, 32'h13, 32'd0, 1'b0, 32'h00000080, 4'b1111, 32'd0, 0);
        applyStimulus("st half", 0, 1'b1, 3'b001, 32'h22, 32'hABCD8001, 1'b0, 32'd0, 4'b1100, 32'h80018001, 0);
        applyStimulus("ld half s", 0, 1'b0, 3'b001, 32'h22, 32'd0, 1'b0, 32'hFFFF8001, 4'b1111, 32'd0, 0);
        applyStimulus("ld half u", 1, 1'b0, 3'b101, 32'h22, 32'd0, 1'b0, 32'h00008001, 4'b1111, 32'd0, 0);
        applyStimulus("ld byte0 s", 0, 1'b0, 3'b000, 32'h10, 32'd0, 1'b0, 32'hFFFFFFEF, 4'b1111, 32'd0, 0);

        // Rejected accesses.
        applyStimulus("err word mis", 0, 1'b0, 3'b010, 32'h6, 32'd0, 1'b1, 32'd0, 4'b0000, 32'd0, 0);
        applyStimulus("err half mis", 1, 1'b0, 3'b001, 32'h5, 32'd0, 1'b1, 32'd0, 4'b0000, 32'd0, 0);
        applyStimulus("err range", 0, 1'b0, 3'b010, 32'h0001_0000, 32'd0, 1'b1, 32'd0, 4'b0000, 32'd0, 0);
        applyStimulus("err size11", 0, 1'b0, 3'b011, 32'h0, 32'd0, 1'b1, 32'd0, 4'b0000, 32'd0, 0);
        applyStimulus("err store", 1, 1'b1, 3'b010, 32'h6, 32'h11111111, 1'b1, 32'd0, 4'b0000, 32'd0, 0);
        applyStimulus("ld after err", 0, 1'b0, 3'b010, 32'h4, 32'd0, 1'b0, 32'd0, 4'b1111, 32'd0, 0);

        // Response stall on port 1 while port 0 offers rspReady.
        applyStimulus("stall", 1, 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'h80ADBEEF, 4'b1111, 32'd0, 5);

        // Reset during the ISSUE cycle of a store.
        @(negedge clk);
        bus.reqAddr0  = 32'h40;
        bus.reqWrite0 = 1'b1;
        bus.reqSize0  = 3'b010;
        bus.reqWdata0 = 32'h12345678;
        bus.reqValid  = 2'b01;
        #1;
        checkOutput("rst accept", 32'(bus.reqReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = 2'b00;
        checkOutput("rst issue memWrite", 32'(bus.memWrite), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst memWrite gated", 32'(bus.memWrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst rspValid", 32'(bus.rspValid), 32'd0);
        checkOutput("rst memAddress", bus.memAddress, 32'd0);
        checkOutput("rst byteMask", 32'(bus.byteMask), 32'd0);
        applyStimulus("ld after rst", 0, 1'b0, 3'b010, 32'h40, 32'd0, 1'b0, 32'd0, 4'b1111, 32'd0, 0);

        // Round robin after a fresh reset: both ports valid continuously.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.reqAddr0  = 32'h10;
        bus.reqAddr1  = 32'h10;
        bus.reqWrite0 = 1'b0;
        bus.reqWrite1 = 1'b0;
        bus.reqSize0  = 3'b010;
        bus.reqSize1  = 3'b010;
        bus.rspReady  = 2'b11;
        bus.reqValid  = 2'b11;
        grants  = 0;
        cyc     = 0;
        lastCyc = -1;
        while (grants < 4 && cyc < 40) begin
            #1;
            if (bus.reqReady != 2'b00) begin
                checkOutput("rr grant", 32'(bus.reqReady), (grants % 2 == 0) ? 32'd1 : 32'd2);
                if (lastCyc >= 0) begin
                    checkOutput("rr spacing", 32'(cyc - lastCyc), 32'd4);
                end
                lastCyc = cyc;
                grants++;
            end
            if (grants < 4) begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("rr grant count", 32'(grants), 32'd4);
        @(negedge clk);
        bus.reqValid = 2'b00;
        repeat (5) @(negedge clk);
        checkOutput("rr drained", 32'(bus.rspValid), 32'd0);
        bus.rspReady = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
